fft_addr_gen: RTL and testbench
===============================

Name: fft_addr_gen

Overview:
- Stage/butterfly sequencer for the in-place radix-2 FFT. Sits directly upstream of the sample RAM and drives its READ_ADDRESS, write_to_cache, SEND_ADDR and mode inputs.
- Also issues operand-capture and write-select strobes, plus twiddle indices, to the butterfly datapath. The datapath drives SEND_DATA.
- Schedule is 4 cycles per butterfly, aligned to the RAM's 2-cycle SEND_ADDR delay and its 1-cycle registered READ_DATA.

Parameters:
- LOG2N, 12, log2 of FFT length; N = 2**LOG2N; 12 matches the 4096-word RAM.
- AW, LOG2N, address width of read_address and send_addr.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  1-cycle request to run a full transform; ignored unless in IDLE.
- busy  out  1  high from the cycle after an accepted start until DONE.
- done  out  1  1-cycle pulse when the last write cycle completes.
- mode  out  1  RAM mode: 1 = AXI host owns RAM (IDLE/DONE), 0 = compute.
- write_to_cache  out  1  RAM read strobe; high in RD_A and RD_B.
- read_address  out  AW  RAM read address.
- send_addr  out  AW  RAM write address; the RAM applies it 2 cycles later.
- cap_a  out  1  datapath latches READ_DATA as operand A (valid in RD_B).
- cap_b  out  1  READ_DATA holds operand B (valid in WR_A).
- wr_sel  out  1  0 = datapath drives A' on SEND_DATA, 1 = B'; meaningful in WR_A/WR_B.
- twiddle_idx  out  LOG2N-1  twiddle ROM index for the current butterfly.
- stage  out  $clog2(LOG2N)  current stage number.
- swap  out  1  high during the bit-reverse pass (FFT_BITREV_EN only); constant 0 otherwise.

Behaviour:
- Reset values: all outputs 0 except mode=1. State = IDLE; counters cleared.
- States: IDLE, RD_A, RD_B, WR_A, WR_B, DONE.
- IDLE: on start go to RD_A with stage=0, k=0.
- Sequence: RD_A -> RD_B -> WR_A -> WR_B.
- After WR_B:
  - k < N/2-1: k++, go to RD_A.
  - else if stage < LOG2N-1: stage++, k=0, go to RD_A.
  - else go to DONE.
- DONE: done=1 for one cycle, mode=1, then IDLE.
- Addressing, combinational from stage s and k:
  - span = 1<<s; pos = k & (span-1); grp = k >> s.
  - a = (grp << (s+1)) | pos; b = a + span.
  - twiddle_idx = pos << (LOG2N-1-s).
- Per-state outputs:
  - RD_A: write_to_cache=1, read_address=a, send_addr=a.
  - RD_B: write_to_cache=1, read_address=b, send_addr=b, cap_a=1.
  - WR_A: cap_b=1, wr_sel=0; RAM writes A' to a.
  - WR_B: wr_sel=1; RAM writes B' to b.
- send_addr in WR_A/WR_B is held at b. Its delayed write lands in the next RD cycles, where write_to_cache suppresses it, so no spurious write occurs.
- mode=0 in RD_A through WR_B. mode=1 in IDLE and DONE, so no compute writes happen outside a transform.
- busy: 1 in RD_A through WR_B and in DONE. done and busy are both high in the DONE cycle.
- Total latency, start to done: LOG2N*(N/2)*4 + 1 cycles.
- start while busy: ignored; no restart, no queueing.
- rst mid-transform: immediate return to IDLE with reset output values; RAM contents are undefined to the host.

Optional Feature:
- Macro FFT_BITREV_EN.
- Defined: a bit-reversal pass precedes stage 0.
  - i runs 0..N-1 with a=i, b=bitrev(i); index pairs with i >= bitrev(i) are skipped with zero cycles spent.
  - Uses the same RD_A..WR_B pattern with swap=1; the datapath writes B to a and A to b.
  - twiddle_idx=0 and stage=0 during the pass.
- Undefined: no pass; swap tied 0; input is expected already bit-reversed.

Decomposition:
- fft_pkg:
  - LOG2N default.
  - State enum type fft_ag_state_t.
  - Localparams N and HALF_N.
  - bitrev function.
- Sub-module fft_pair_addr: combinational (stage, k) -> (a, b, twiddle_idx), instantiated once.

Test Plan:
- Reset: assert rst for 3 cycles -> mode=1, busy=0, done=0, write_to_cache=0, all addresses 0.
- LOG2N=3 stage pairs: start -> stage0 (0,1)(2,3)(4,5)(6,7); stage1 (0,2)(1,3)(4,6)(5,7); stage2 (0,4)(1,5)(2,6)(3,7). Twiddle: stage1 0,2,0,2; stage2 0,1,2,3.
- Latency, LOG2N=3: done pulses 49 cycles after the start cycle, busy high throughout. LOG2N=12: done after 98305 cycles.
- Write alignment: use a RAM model with a 2-cycle SEND_ADDR delay. Every write lands only in WR_A/WR_B at a/b; zero writes occur in RD cycles.
- Mid-run controls: start pulsed while busy -> no effect. rst asserted in stage1 WR_A -> next cycle IDLE, mode=1; a new start then restarts from stage0, k=0.
- FFT_BITREV_EN, LOG2N=3: pass swaps only pairs (1,4) and (3,6), swap=1, taking 8 cycles before stage0; total latency 57 cycles.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 FFT butterfly sequencer.
// Holds the default transform size, FSM state type and bit-reverse helper.
package fft_pkg;

  localparam int DEF_LOG2N = 12;
  localparam int N         = 1 << DEF_LOG2N;
  localparam int HALF_N    = N / 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_WR_A,
    S_WR_B,
    S_DONE
  } fft_ag_state_t;

  // Reverses the low w bits of v; bits at and above w come back as 0.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      if (j < w) r[j] = v[w-1-j];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pair_addr.sv
// Butterfly operand addressing: maps (stage, k) to the pair (a, b)
// and the twiddle ROM index used by that butterfly.
module fft_pair_addr
  import fft_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N,
  parameter int AW    = LOG2N,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic [SW-1:0]    stage,
  input  logic [LOG2N-2:0] k,
  output logic [AW-1:0]    a,
  output logic [AW-1:0]    b,
  output logic [LOG2N-2:0] twiddle_idx
);

  logic [AW-1:0] kx;
  logic [AW-1:0] span;
  logic [AW-1:0] pos;
  logic [AW-1:0] grp;
  int            sh;

  always_comb begin
    sh   = int'(stage);
    kx   = AW'(k);
    span = AW'(1) << sh;
    pos  = kx & (span - AW'(1));
    grp  = kx >> sh;
    a    = (grp << (sh + 1)) | pos;
    b    = a + span;
    twiddle_idx =
      (LOG2N-1)'(pos << (LOG2N - 1 - sh));
  end

endmodule

// File: rtl/fft_addr_gen.sv
// In-place radix-2 FFT stage/butterfly sequencer, 4 cycles per butterfly.
// Define FFT_BITREV_EN to prepend a bit-reversal swap pass before stage 0.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N,
  parameter int AW    = LOG2N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mode,
  output logic                     write_to_cache,
  output logic [AW-1:0]            read_address,
  output logic [AW-1:0]            send_addr,
  output logic                     cap_a,
  output logic                     cap_b,
  output logic                     wr_sel,
  output logic [LOG2N-2:0]         twiddle_idx,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     swap
);

  localparam int SW = $clog2(LOG2N);
  localparam int NN = 1 << LOG2N;
  localparam int KW = LOG2N - 1;
  localparam logic [KW-1:0] KMAX = KW'(NN/2 - 1);
  localparam logic [SW-1:0] SMAX = SW'(LOG2N - 1);

  fft_ag_state_t state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [KW-1:0] k_q, k_d;

  logic [AW-1:0]    pa, pb, ra, rb;
  logic [LOG2N-2:0] ptw;
  logic             active;
  logic             rev_q;

  fft_pair_addr #(
    .LOG2N(LOG2N),
    .AW   (AW),
    .SW   (SW)
  ) u_pair (
    .stage      (stage_q),
    .k          (k_q),
    .a          (pa),
    .b          (pb),
    .twiddle_idx(ptw)
  );

`ifdef FFT_BITREV_EN
  logic             rev_d;
  logic [LOG2N-1:0] i_q, i_d, nxt_i;
  logic [LOG2N:0]   base;
  logic [31:0]      jv;
  logic             found;

  // Next index at or after base whose pair is not yet swapped;
  // skipped indices cost no cycles.
  always_comb begin
    base  = (state_q == S_IDLE) ? '0
          : {1'b0, i_q} + (LOG2N+1)'(1);
    found = 1'b0;
    nxt_i = '0;
    jv    = '0;
    for (int j = 0; j < NN; j++) begin
      jv = 32'(j);
      if (!found && (LOG2N+1)'(j) >= base
          && jv < bitrev(jv, LOG2N)) begin
        found = 1'b1;
        nxt_i = LOG2N'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rev_q <= 1'b0;
      i_q   <= '0;
    end else begin
      rev_q <= rev_d;
      i_q   <= i_d;
    end
  end

  assign ra = rev_q ? AW'(i_q) : pa;
  assign rb = rev_q
            ? AW'(bitrev(32'(i_q), LOG2N)) : pb;
`else
  assign rev_q = 1'b0;
  assign ra    = pa;
  assign rb    = pb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
`ifdef FFT_BITREV_EN
    rev_d   = rev_q;
    i_d     = i_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_A;
          stage_d = '0;
          k_d     = '0;
`ifdef FFT_BITREV_EN
          rev_d   = found;
          i_d     = nxt_i;
`endif
        end
      end
      S_RD_A: state_d = S_RD_B;
      S_RD_B: state_d = S_WR_A;
      S_WR_A: state_d = S_WR_B;
      S_WR_B: begin
        state_d = S_RD_A;
`ifdef FFT_BITREV_EN
        if (rev_q) begin
          if (found) begin
            i_d = nxt_i;
          end else begin
            rev_d = 1'b0;
            i_d   = '0;
          end
        end else
`endif
        if (k_q != KMAX) begin
          k_d = k_q + KW'(1);
        end else if (stage_q != SMAX) begin
          stage_d = stage_q + SW'(1);
          k_d     = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        stage_d = '0;
        k_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // send_addr is held at b through the write cycles; those delayed
  // addresses land in RD cycles where write_to_cache masks them.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mode           = 1'b1;
    write_to_cache = 1'b0;
    read_address   = '0;
    send_addr      = '0;
    cap_a          = 1'b0;
    cap_b          = 1'b0;
    wr_sel         = 1'b0;
    active         = 1'b0;
    unique case (state_q)
      S_RD_A: begin
        active         = 1'b1;
        write_to_cache = 1'b1;
        read_address   = ra;
        send_addr      = ra;
      end
      S_RD_B: begin
        active         = 1'b1;
        write_to_cache = 1'b1;
        read_address   = rb;
        send_addr      = rb;
        cap_a          = 1'b1;
      end
      S_WR_A: begin
        active    = 1'b1;
        cap_b     = 1'b1;
        send_addr = rb;
      end
      S_WR_B: begin
        active    = 1'b1;
        wr_sel    = 1'b1;
        send_addr = rb;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    if (active) begin
      busy = 1'b1;
      mode = 1'b0;
    end
    twiddle_idx = (active && !rev_q) ? ptw : '0;
    swap        = active && rev_q;
  end

  assign stage = stage_q;

endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen at LOG2N=3 with a 2-cycle-delay RAM model.
module tb_fft_addr_gen;

  localparam int L  = 3;
  localparam int AW = L;
  localparam int N  = 1 << L;
  localparam int SW = $clog2(L);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, mode;
  logic          write_to_cache;
  logic [AW-1:0] read_address, send_addr;
  logic          cap_a, cap_b, wr_sel, swap;
  logic [L-2:0]  twiddle_idx;
  logic [SW-1:0] stage;

  always #5 clk = ~clk;

  fft_addr_gen #(.LOG2N(L), .AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .mode          (mode),
    .write_to_cache(write_to_cache),
    .read_address  (read_address),
    .send_addr     (send_addr),
    .cap_a         (cap_a),
    .cap_b         (cap_b),
    .wr_sel        (wr_sel),
    .twiddle_idx   (twiddle_idx),
    .stage         (stage),
    .swap          (swap)
  );

  typedef struct {
    int addr; int cap; int tw; int stg; int swp;
  } rd_t;
  typedef struct { int addr; int sel; } wr_t;

  rd_t rd_q[$];
  wr_t wr_q[$];
  int  done_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  sa1 = 0;
  int  sa2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rev(int v);
    int r = 0;
    for (int j = 0; j < L; j++)
      if ((v >> j) & 1) r |= 1 << (L - 1 - j);
    return r;
  endfunction

  task automatic push_bf(int a, int b, int tw,
                         int s, int sw);
    rd_q.push_back(rd_t'{a, 0, tw, s, sw});
    rd_q.push_back(rd_t'{b, 1, tw, s, sw});
    wr_q.push_back(wr_t'{a, 0});
    wr_q.push_back(wr_t'{b, 1});
  endtask

  // Expected schedule built from the butterfly definition:
  // groups of 2*span, members j and j+span, twiddle j*N/(2*span).
  task automatic push_transform();
    int nops = 0;
`ifdef FFT_BITREV_EN
    for (int i = 0; i < N; i++)
      if (i < rev(i)) begin
        push_bf(i, rev(i), 0, 0, 1);
        nops++;
      end
`endif
    for (int s = 0; s < L; s++) begin
      int span = 1 << s;
      for (int g = 0; g < N; g += 2 * span)
        for (int j = 0; j < span; j++) begin
          push_bf(g + j, g + j + span,
                  j * (N / (2 * span)), s, 0);
          nops++;
        end
    end
    done_q.push_back(cyc + 4 * nops + 1);
  endtask

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d",
               name, got, exp);
    end
  endtask

  // Monitor: RAM model writes at t to send_addr(t-2)
  // whenever the RAM is in compute mode and not reading.
  always @(negedge clk) begin : mon
    rd_t e;
    wr_t w;
    int  wa;
    int  ex;
    wa  = sa2;
    sa2 = sa1;
    sa1 = int'(send_addr);
    if (write_to_cache === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected addr=%0d expected none",
                 read_address);
      end else begin
        e = rd_q.pop_front();
        if (int'(read_address) != e.addr
            || int'(cap_a) != e.cap
            || int'(twiddle_idx) != e.tw
            || int'(stage) != e.stg
            || int'(swap) != e.swp
            || mode !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display({"FAIL rd got addr=%0d cap_a=%0d tw=%0d",
                    " stage=%0d swap=%0d mode=%0b busy=%0b",
                    " expected addr=%0d cap_a=%0d tw=%0d",
                    " stage=%0d swap=%0d mode=0 busy=1"},
                   read_address, cap_a, twiddle_idx, stage,
                   swap, mode, busy, e.addr, e.cap, e.tw,
                   e.stg, e.swp);
        end
      end
    end
    if (mode === 1'b0 && write_to_cache === 1'b0) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected addr=%0d expected none",
                 wa);
      end else begin
        w = wr_q.pop_front();
        if (wa != w.addr || int'(wr_sel) != w.sel
            || int'(cap_b) != int'(w.sel == 0)
            || busy !== 1'b1) begin
          errors++;
          $display({"FAIL wr got addr=%0d wr_sel=%0d",
                    " cap_b=%0d busy=%0b expected addr=%0d",
                    " wr_sel=%0d cap_b=%0d busy=1"},
                   wa, wr_sel, cap_b, busy, w.addr, w.sel,
                   int'(w.sel == 0));
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cycle=%0d", cyc);
      end else begin
        ex = done_q.pop_front();
        if (cyc != ex || busy !== 1'b1
            || mode !== 1'b1 || rd_q.size() != 0) begin
          errors++;
          $display({"FAIL done got cycle=%0d busy=%0b",
                    " mode=%0b pending_rd=%0d expected",
                    " cycle=%0d busy=1 mode=1 pending_rd=0"},
                   cyc, busy, mode, rd_q.size(), ex);
        end
      end
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    push_transform();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 4000 && done_q.size() != 0; n++)
      @(posedge clk);
    #1;
    if (done_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout got=no_done expected=done");
      done_q.delete();
      rd_q.delete();
      wr_q.delete();
    end
  endtask

  initial begin
    bit hit;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mode", int'(mode), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_wtc", int'(write_to_cache), 0);
    chk("reset_raddr", int'(read_address), 0);
    chk("reset_saddr", int'(send_addr), 0);
    chk("reset_strobes",
        int'({cap_a, cap_b, wr_sel, swap}), 0);
    chk("reset_tw", int'(twiddle_idx), 0);
    chk("reset_stage", int'(stage), 0);
    rst = 1'b0;

    for (int t = 0; t < 3; t++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      do_start();
      if (t != 0) begin
        repeat ($urandom_range(3, 30)) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_done();
    end

    do_start();
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      @(posedge clk);
      #1;
      hit = (stage == SW'(1)) && cap_b;
    end
    chk("reach_stage1_wr_a", int'(hit), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rd_q.delete();
    wr_q.delete();
    done_q.delete();
    chk("midrst_mode", int'(mode), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_wtc", int'(write_to_cache), 0);
    chk("midrst_stage", int'(stage), 0);
    rst = 1'b0;

    do_start();
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("left_rd", rd_q.size(), 0);
    chk("left_wr", wr_q.size(), 0);
    chk("idle_busy", int'(busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
